// File: rtl/rom_reader_if.sv
// rtl/rom_reader_if.sv - output word stream bundle for rom_reader
//
// Purpose: groups the valid/ready word stream leaving rom_reader.
// Signals:
//   valid  word available at the head of the reader FIFO
//   ready  downstream accepts the head word
//   data   ROM word
//   index  ROM address the word was read from
//   last   final word of the burst
// Modports: master (rom_reader side), slave (consumer side).

interface rom_reader_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  index;
  logic              last;

  modport master (output valid, output data, output index, output last, input ready);
  modport slave  (input valid, input data, input index, input last, output ready);
endinterface

// File: rtl/rom_reader.sv
// rtl/rom_reader.sv - burst sequencer between a sequential ROM and a word stream
//
// Purpose: on a start pulse, drives the ROM enable for word_count reads,
// captures each returned word with its ROM address into a small FIFO and
// presents the FIFO head on a valid/ready stream. done pulses once the
// final word has been accepted.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           burst request (sampled only while idle)
//   word_count      burst length, sampled with start
//   rom_en          ROM enable
//   rom_data        ROM output word
//   rom_cnt         ROM address counter
//   m               output stream (rom_reader_if master)
//   busy            block is not idle
//   done            one-cycle burst-complete pulse

module rom_reader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  word_count,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [IDX_W-1:0]  rom_cnt,
  rom_reader_if.master      m,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  logic [DATA_W-1:0] r_mem_data  [DEPTH];
  logic [IDX_W-1:0]  r_mem_index [DEPTH];
  logic              r_mem_last  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic [CNT_W:0]    w_occ;
  logic              w_room;

  assign w_valid     = (r_count != '0);
  assign w_push      = r_inflight;
  assign w_pop       = w_valid && m.ready;
  assign w_head_last = r_mem_last[r_rd_ptr];

  // Space is judged on entries held plus the word still coming back from
  // the ROM; a pop in the same cycle is deliberately not counted as free.
  assign w_occ  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_room = (w_occ < DEPTH_C);

  assign rom_en = (r_state == S_RUN) && w_room && (r_remaining != '0);

  // Head fields are forced to zero while empty so reset and idle outputs are clean.
  assign m.valid = w_valid;
  assign m.data  = w_valid ? r_mem_data[r_rd_ptr]  : '0;
  assign m.index = w_valid ? r_mem_index[r_rd_ptr] : '0;
  assign m.last  = w_valid ? w_head_last           : 1'b0;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  // FIFO storage carries no reset; only the pointers and count define content.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_data[r_wr_ptr]  <= rom_data;
      r_mem_index[r_wr_ptr] <= rom_cnt;
      r_mem_last[r_wr_ptr]  <= r_inflight_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= rom_en;
      r_inflight_last <= rom_en && (r_remaining == IDX_W'(1));

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              r_remaining <= word_count;
              r_state     <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (rom_en) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == IDX_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_reader.sv
// tb/tb_rom_reader.sv - directed self-checking bench for rom_reader

module tb_rom_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  word_count = 8'd0;
  logic        rom_en;
  logic [31:0] rom_data;
  logic [7:0]  rom_cnt;
  logic        busy;
  logic        done;

  logic        rom_set = 1'b0;
  logic [7:0]  rom_set_val = 8'd0;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt;
  int done_cnt;

  rom_reader_if #(.DATA_W(32), .IDX_W(8)) m_if ();

  rom_reader #(.DATA_W(32), .IDX_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .rom_cnt    (rom_cnt),
    .m          (m_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // 100-word sequential ROM, mem[i] = 0xA000_0000 + i; counter is loadable by the bench.
  always @(posedge clk) begin
    if (rom_set) begin
      rom_cnt <= rom_set_val;
    end else if (rom_en) begin
      if (rom_cnt == 8'd99) begin
        rom_cnt  <= 8'd0;
        rom_data <= 32'hA000_0000;
      end else begin
        rom_cnt  <= rom_cnt + 8'd1;
        rom_data <= 32'hA000_0000 + 32'(rom_cnt) + 32'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with m_ready already set to 1; checks n words
  // starting at ROM address first, last flag on word number total-1.
  task automatic collect(input int n, input int first, input int total);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      int idx = (first + k) % 100;
      while (!m_if.valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("valid_wait", 32'(m_if.valid), 32'd1);
      chk("data", m_if.data, 32'hA000_0000 + 32'(idx));
      chk("index", 32'(m_if.index), 32'(idx));
      chk("last", 32'(m_if.last), (k == total - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    chk({tag, "_valid"}, 32'(m_if.valid), 32'd0);
    chk({tag, "_data"}, m_if.data, 32'd0);
    chk({tag, "_index"}, 32'(m_if.index), 32'd0);
    chk({tag, "_last"}, 32'(m_if.last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    m_if.ready = 1'b0;

    // Reset, ROM counter at 99 so the first read returns address 0.
    rom_set = 1'b1;
    rom_set_val = 8'd99;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    rom_set = 1'b0;
    @(negedge clk);

    // Burst of 3 with m_ready held high.
    m_if.ready = 1'b1;
    start = 1'b1;
    word_count = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b3_rom_en_c1", 32'(rom_en), 32'd1);
    chk("b3_busy_c1", 32'(busy), 32'd1);
    chk("b3_valid_c1", 32'(m_if.valid), 32'd0);
    @(negedge clk);
    chk("b3_valid_c2", 32'(m_if.valid), 32'd0);
    @(negedge clk);
    collect(3, 0, 3);
    chk("b3_done", 32'(done), 32'd1);
    chk("b3_busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b3_done_pulse", 32'(done), 32'd0);

    // Backpressure: m_ready low, 10 words.
    m_if.ready = 1'b0;
    rom_set = 1'b1;
    rom_set_val = 8'd99;
    @(negedge clk);
    rom_set = 1'b0;
    start = 1'b1;
    word_count = 8'd10;
    @(negedge clk);
    start = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (rom_en) en_cnt++;
      @(negedge clk);
    end
    chk("bp_en_cycles", 32'(en_cnt), 32'd4);
    chk("bp_rom_en_low", 32'(rom_en), 32'd0);
    chk("bp_valid", 32'(m_if.valid), 32'd1);
    chk("bp_head_data", m_if.data, 32'hA000_0000);
    chk("bp_head_index", 32'(m_if.index), 32'd0);
    m_if.ready = 1'b1;
    collect(10, 0, 10);
    chk("bp_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("bp_done_pulse", 32'(done), 32'd0);

    // Address wrap: counter 97, 5 words -> 98, 99, 0, 1, 2.
    rom_set = 1'b1;
    rom_set_val = 8'd97;
    @(negedge clk);
    rom_set = 1'b0;
    start = 1'b1;
    word_count = 8'd5;
    @(negedge clk);
    start = 1'b0;
    collect(5, 98, 5);
    chk("wrap_done", 32'(done), 32'd1);
    @(negedge clk);

    // Zero-length burst.
    start = 1'b1;
    word_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_rom_en", 32'(rom_en), 32'd0);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rom_en || busy) en_cnt++;
    end
    chk("zero_quiet", 32'(en_cnt), 32'd0);
    chk("zero_done_pulse", 32'(done), 32'd0);

    // Mid-burst reset after 2 of 8 words accepted.
    rom_set = 1'b1;
    rom_set_val = 8'd99;
    @(negedge clk);
    rom_set = 1'b0;
    start = 1'b1;
    word_count = 8'd8;
    @(negedge clk);
    start = 1'b0;
    collect(2, 0, 8);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_after", 32'(m_if.valid), 32'd0);
    // ROM issued reads for addresses 0..4 before reset took effect.
    start = 1'b1;
    word_count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    collect(2, 5, 2);
    chk("midrst_done", 32'(done), 32'd1);
    @(negedge clk);

    // start pulsed mid-burst is ignored.
    m_if.ready = 1'b0;
    start = 1'b1;
    word_count = 8'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    word_count = 8'd50;
    @(negedge clk);
    start = 1'b0;
    word_count = 8'd0;
    chk("ign_busy", 32'(busy), 32'd1);
    m_if.ready = 1'b1;
    collect(6, 7, 6);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_busy_end", 32'(busy), 32'd0);
    done_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rom_en || busy || m_if.valid) en_cnt++;
    end
    chk("ign_single_done", 32'(done_cnt), 32'd0);
    chk("ign_no_restart", 32'(en_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
